// File: rtl/collatz_pkg.sv
// Shared types for the Collatz iterator: FSM states and error codes.
package collatz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ZERO  = 2'd1,
    ERR_OVF   = 2'd2,
    ERR_LIMIT = 2'd3
  } err_t;

endpackage : collatz_pkg

// File: rtl/collatz_step.sv
// One Collatz step: halve even values, 3x+1 odd values with a widened
// overflow check so the caller can refuse results that do not fit WIDTH bits.
module collatz_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf
);

  logic [WIDTH+1:0] cur_wide;
  logic [WIDTH+1:0] tripled;

  // 3*cur+1 at WIDTH+2 bits cannot itself overflow; the top two bits flag results beyond WIDTH
  always_comb begin
    cur_wide = {2'b00, cur};
    tripled  = (cur_wide << 1) + cur_wide + (WIDTH+2)'(1);
    nxt      = cur >> 1;
    ovf      = 1'b0;
    if (cur[0]) begin
      nxt = tripled[WIDTH-1:0];
      ovf = |tripled[WIDTH+1:WIDTH];
    end
  end

endmodule : collatz_step

// File: rtl/collatz_engine.sv
// Parametrised Collatz iterator with step counting, peak tracking and
// fault reporting (zero input, arithmetic overflow, runaway step count).
module collatz_engine
  import collatz_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CWIDTH    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [WIDTH-1:0]  n,
  output logic [WIDTH-1:0]  dout,
  output logic [CWIDTH-1:0] steps,
  output logic [WIDTH-1:0]  peak,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  localparam logic [CWIDTH-1:0] MAX_STEPS_C = CWIDTH'(MAX_STEPS);

  state_t            state_q, state_d;
  err_t              err_q, err_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic [CWIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0]  peak_q, peak_d;

  logic [WIDTH-1:0]  step_nxt;
  logic              step_ovf;

  collatz_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .cur(dout_q),
    .nxt(step_nxt),
    .ovf(step_ovf)
  );

  // Next-state logic: go restarts from any state, otherwise RUN iterates once per clock
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    dout_d  = dout_q;
    steps_d = steps_q;
    peak_d  = peak_q;
    if (go) begin
      dout_d  = n;
      steps_d = '0;
      peak_d  = n;
      if (n == '0) begin
        state_d = ERR;
        err_d   = ERR_ZERO;
      end else begin
        state_d = RUN;
        err_d   = ERR_NONE;
      end
    end else if (state_q == RUN) begin
      if (dout_q == WIDTH'(1)) begin
        state_d = DONE;
      end else if (steps_q == MAX_STEPS_C) begin
        state_d = ERR;
        err_d   = ERR_LIMIT;
      end else if (step_ovf) begin
        state_d = ERR;
        err_d   = ERR_OVF;
      end else begin
        dout_d  = step_nxt;
        steps_d = steps_q + CWIDTH'(1);
        if (step_nxt > peak_q) begin
          peak_d = step_nxt;
        end
      end
    end
  end

  // State and datapath registers; synchronous reset wins over go
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      dout_q  <= '0;
      steps_q <= '0;
      peak_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      steps_q <= steps_d;
      peak_q  <= peak_d;
    end
  end

  assign dout  = dout_q;
  assign steps = steps_q;
  assign peak  = peak_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign err   = err_q;

endmodule : collatz_engine

// File: doc/collatz_engine.md
Name: collatz_engine

Overview:
Parametrised, fault-reporting Collatz iterator. It is the successor to the fixed 32-bit iterator.
- Width and step limit are configurable.
- Counts steps and tracks the peak value.
- Detects zero input, arithmetic overflow and a runaway step count, and terminates with an error code.
- Sits behind the same go/n/dout/done style interface as a reusable datapath engine for lab exercises and bus-attached peripherals.

Parameters:
WIDTH, 32, bit width of n, dout and peak
CWIDTH, 16, bit width of the step counter
MAX_STEPS, 1000, step limit; must satisfy MAX_STEPS <= 2**CWIDTH-1

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  synchronous, active-high reset
go  input  1  load n and start iterating; honoured in every state
n  input  WIDTH  start value; sampled only when go=1
dout  output  WIDTH  current iteration value
steps  output  CWIDTH  number of iterations applied since load
peak  output  WIDTH  maximum value dout has held since load
busy  output  1  high while iterating (state RUN)
done  output  1  high when the sequence reached 1 without error (state DONE)
err  output  2  0=none, 1=zero input, 2=overflow, 3=step limit; nonzero only in state ERR

Behaviour:
- Reset (synchronous, active-high, dominates go):
  - state=IDLE.
  - dout=0, steps=0, peak=0, done=0, err=0, busy=0.
- States: IDLE, RUN, DONE, ERR. Outputs are registered or decoded from the registered state, with no combinational path from go/n to any output.
- go=1 in any state (including mid-RUN, DONE or ERR) at edge k:
  - dout=n, steps=0, peak=n, done=0.
  - If n==0: state=ERR, err=1.
  - Otherwise: state=RUN, err=0.
  - The in-flight computation is abandoned.
- RUN, go=0, evaluated at each edge in this priority order:
  1. dout==1: state=DONE. dout, steps and peak hold.
  2. steps==MAX_STEPS: state=ERR, err=3. dout and steps hold.
  3. dout even: dout=dout>>1, steps+=1.
  4. dout odd: compute 3*dout+1 at WIDTH+2 bits.
     - If the result exceeds 2**WIDTH-1: state=ERR, err=2. dout holds its last valid value and steps does not increment.
     - Otherwise: dout=result, steps+=1.
  5. After any dout update: peak=max(peak, new dout).
- Latency: one iteration per clock. For start value n requiring S steps:
  - dout==1 after edge k+S.
  - done=1 after edge k+S+1.
- IDLE, DONE and ERR hold all outputs until go or reset.
- n==1: done=1 one edge after load, steps=0, peak=1.
- steps never wraps, because MAX_STEPS bounds it.

Decomposition:
- collatz_pkg holds:
  - state_t enum (IDLE, RUN, DONE, ERR).
  - err_t enum (ERR_NONE, ERR_ZERO, ERR_OVF, ERR_LIMIT), 2 bits.
- Sub-module collatz_step, parametrised by WIDTH, is purely combinational.
  - Input: cur.
  - Outputs: nxt[WIDTH-1:0] and ovf.
  - It isolates the even/odd arithmetic and the widened overflow check.
- collatz_engine contains the FSM, counters and peak register.

Test Plan:
- Default params; reset, then go with n=6 -> dout sequence 6,3,10,5,16,8,4,2,1; done rises one edge after dout=1; steps=8, peak=16, err=0; busy high for 9 cycles.
- Default params; n=27 -> done with steps=111, peak=9232, err=0; n=1 -> done one edge after go, steps=0, peak=1.
- WIDTH=8; n=255 -> err=2 one edge after go, dout=255, steps=0, busy=0, done=0; n=27 -> err=2 once 3*dout+1 exceeds 255, dout holds the last in-range value.
- MAX_STEPS=5, n=6 -> after 5 steps dout=8, steps=5; next edge err=3, done=0, dout=8.
- n=0 -> err=1 one edge after go, busy never rises.
- Go with n=7 mid-run of n=27 -> dout=7, steps=0, peak=7 next edge, then completes with steps=16, peak=52.
- Reset asserted mid-run together with go -> all outputs 0, state IDLE.
